// File: rtl/transducer_scan_driver_if.sv
// rtl/transducer_scan_driver_if.sv - control/status bundle for the transducer scan driver
//
// Purpose: groups sweep control inputs and drive/status outputs of
//          transducer_scan_driver into one port.
// Signals:
//   start      sweep request, one cycle
//   stop       abort, level-sensitive
//   cont_mode  1 = wrap to the first channel at end of sweep
//   ch_mask    per-channel enable (only with TSCAN_CH_MASK_EN)
//   trans      one-hot transducer drive
//   busy       sweep in progress
//   done       one-cycle end-of-sweep pulse
//   ch_idx     channel currently in ON or GAP
// Modports: master drives control and observes status; slave is the driver.
interface transducer_scan_driver_if #(
    parameter int N_CH = 49
);
    localparam int CW = $clog2(N_CH);

    logic            start;
    logic            stop;
    logic            cont_mode;
`ifdef TSCAN_CH_MASK_EN
    logic [N_CH-1:0] ch_mask;
`endif
    logic [N_CH-1:0] trans;
    logic            busy;
    logic            done;
    logic [CW-1:0]   ch_idx;

`ifdef TSCAN_CH_MASK_EN
    modport master (output start, stop, cont_mode, ch_mask,
                    input  trans, busy, done, ch_idx);
    modport slave  (input  start, stop, cont_mode, ch_mask,
                    output trans, busy, done, ch_idx);
`else
    modport master (output start, stop, cont_mode,
                    input  trans, busy, done, ch_idx);
    modport slave  (input  start, stop, cont_mode,
                    output trans, busy, done, ch_idx);
`endif
endinterface

// File: rtl/transducer_scan_driver.sv
// rtl/transducer_scan_driver.sv - steps a PWM burst across N_CH transducer outputs
//
// Purpose: drives one PWM burst (DWELL_PERIODS periods) on each enabled
//          channel in ascending order, each followed by GAP_PERIODS silent
//          periods. Single sweep or continuous wrap, with abort.
// Ports:
//   CLK   system clock
//   RST   synchronous reset, active-high
//   bus   transducer_scan_driver_if.slave (start, stop, cont_mode,
//         [ch_mask], trans, busy, done, ch_idx)
// Build option: define TSCAN_CH_MASK_EN to add the ch_mask channel enable,
//               latched at start acceptance and at each sweep wrap.
module transducer_scan_driver #(
    parameter int N_CH          = 49,
    parameter int PWM_PERIOD    = 1250,
    parameter int PWM_HIGH      = 625,
    parameter int DWELL_PERIODS = 40000,
    parameter int GAP_PERIODS   = 40000
) (
    input  logic                   CLK,
    input  logic                   RST,
    transducer_scan_driver_if.slave bus
);
    localparam int CW      = $clog2(N_CH);
    localparam int PCW     = $clog2(PWM_PERIOD);
    localparam int PER_MAX = (DWELL_PERIODS > GAP_PERIODS) ? DWELL_PERIODS : GAP_PERIODS;
    localparam int PW      = $clog2(PER_MAX + 1);

    localparam logic [PCW-1:0] PWM_LAST   = PCW'(PWM_PERIOD - 1);
    localparam logic [PCW-1:0] PWM_HI     = PCW'(PWM_HIGH);
    localparam logic [PW-1:0]  DWELL_LAST = PW'(DWELL_PERIODS - 1);
    localparam logic [PW-1:0]  GAP_LAST   = PW'((GAP_PERIODS > 0) ? GAP_PERIODS - 1 : 0);
    localparam logic [N_CH-1:0] ONE_HOT0  = {{(N_CH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_ON, S_GAP} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   ch_idx_q, ch_idx_n;
    logic [PCW-1:0]  pwm_cnt, pwm_n;
    logic [PW-1:0]   per_cnt, per_n;
    logic            done_n;
    logic [N_CH-1:0] trans_q;
    logic            busy_q;
    logic            done_q;

    // sweep_mask selects the first channel when a sweep starts or wraps;
    // live_mask governs stepping to the next channel inside a sweep.
    logic [N_CH-1:0] sweep_mask;
    logic [N_CH-1:0] live_mask;
`ifdef TSCAN_CH_MASK_EN
    logic [N_CH-1:0] mask_q, mask_n;
    assign sweep_mask = bus.ch_mask;
    assign live_mask  = mask_q;
`else
    assign sweep_mask = '1;
    assign live_mask  = '1;
`endif

    logic          first_found, next_found;
    logic [CW-1:0] first_idx, next_idx;

    // Lowest enabled channel overall, and lowest enabled channel above ch_idx.
    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        next_found  = 1'b0;
        next_idx    = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (sweep_mask[i]) begin
                first_found = 1'b1;
                first_idx   = CW'(i);
            end
            if (live_mask[i] && (i > int'(ch_idx_q))) begin
                next_found = 1'b1;
                next_idx   = CW'(i);
            end
        end
    end

    logic period_end;
    logic advance;
    assign period_end = (pwm_cnt == PWM_LAST);

    always_comb begin
        state_n  = state;
        ch_idx_n = ch_idx_q;
        pwm_n    = pwm_cnt;
        per_n    = per_cnt;
        done_n   = 1'b0;
        advance  = 1'b0;
`ifdef TSCAN_CH_MASK_EN
        mask_n   = mask_q;
`endif
        case (state)
            S_IDLE: begin
                pwm_n = '0;
                per_n = '0;
                if (bus.start && !bus.stop) begin
`ifdef TSCAN_CH_MASK_EN
                    mask_n = sweep_mask;
`endif
                    if (first_found) begin
                        state_n  = S_ON;
                        ch_idx_n = first_idx;
                    end else begin
                        // nothing enabled: report an empty sweep at once
                        done_n = 1'b1;
                    end
                end
            end
            S_ON, S_GAP: begin
                if (period_end) begin
                    pwm_n = '0;
                    per_n = per_cnt + 1'b1;
                end else begin
                    pwm_n = pwm_cnt + 1'b1;
                end
                if (bus.stop) begin
                    state_n  = S_IDLE;
                    ch_idx_n = '0;
                    pwm_n    = '0;
                    per_n    = '0;
                end else if (period_end && state == S_ON && per_cnt == DWELL_LAST) begin
                    if (GAP_PERIODS > 0) begin
                        state_n = S_GAP;
                        pwm_n   = '0;
                        per_n   = '0;
                    end else begin
                        advance = 1'b1;
                    end
                end else if (period_end && state == S_GAP && per_cnt == GAP_LAST) begin
                    advance = 1'b1;
                end
            end
            default: begin
                state_n  = S_IDLE;
                ch_idx_n = '0;
                pwm_n    = '0;
                per_n    = '0;
            end
        endcase

        // Current channel finished: next channel, wrap, or end of sweep.
        if (advance) begin
            pwm_n = '0;
            per_n = '0;
            if (next_found) begin
                state_n  = S_ON;
                ch_idx_n = next_idx;
            end else if (bus.cont_mode && first_found) begin
                state_n  = S_ON;
                ch_idx_n = first_idx;
`ifdef TSCAN_CH_MASK_EN
                mask_n   = sweep_mask;
`endif
            end else begin
                state_n  = S_IDLE;
                ch_idx_n = '0;
                done_n   = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_IDLE;
            ch_idx_q <= '0;
            pwm_cnt  <= '0;
            per_cnt  <= '0;
            trans_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef TSCAN_CH_MASK_EN
            mask_q   <= '0;
`endif
        end else begin
            state    <= state_n;
            ch_idx_q <= ch_idx_n;
            pwm_cnt  <= pwm_n;
            per_cnt  <= per_n;
            busy_q   <= (state_n != S_IDLE);
            done_q   <= done_n;
            // Drive lags state by one cycle, so a stop still lets the
            // current cycle's drive out and silences from the next edge.
            trans_q  <= (state == S_ON && pwm_cnt < PWM_HI) ? (ONE_HOT0 << ch_idx_q) : '0;
`ifdef TSCAN_CH_MASK_EN
            mask_q   <= mask_n;
`endif
        end
    end

    assign bus.trans  = trans_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.ch_idx = ch_idx_q;
endmodule

// File: tb/tb_transducer_scan_driver.sv
// tb/tb_transducer_scan_driver.sv - directed vector bench for transducer_scan_driver
module tb_transducer_scan_driver;
    localparam int N = 4;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    transducer_scan_driver_if #(.N_CH(N)) ifa ();
    transducer_scan_driver_if #(.N_CH(N)) ifb ();

    transducer_scan_driver #(
        .N_CH(N), .PWM_PERIOD(10), .PWM_HIGH(4), .DWELL_PERIODS(3), .GAP_PERIODS(2)
    ) dut_a (
        .CLK(CLK), .RST(RST), .bus(ifa)
    );

    transducer_scan_driver #(
        .N_CH(N), .PWM_PERIOD(10), .PWM_HIGH(4), .DWELL_PERIODS(3), .GAP_PERIODS(0)
    ) dut_b (
        .CLK(CLK), .RST(RST), .bus(ifb)
    );

    typedef struct {
        int         cyc;
        logic [3:0] trans;
        logic       busy;
        logic       done;
        logic [1:0] ch;
    } vec_t;

    vec_t tbl [13];

    int checks     = 0;
    int errors     = 0;
    int onehot_err = 0;
    int vi, wa, wb, dcount, quiet_err;

    // Cycle n is the interval following clock edge n; edge 0 accepts start.
    task automatic step();
        @(posedge CLK);
        #1;
        if ($countones(ifa.trans) > 1 || $countones(ifb.trans) > 1) onehot_err++;
    endtask

    task automatic check(input string name, input int n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got 0x%0h required 0x%0h", name, n, act, exp);
        end
    endtask

    function automatic logic [31:0] pk(input logic [3:0] t, input logic b, input logic d, input logic [1:0] c);
        return {24'd0, t, b, d, c};
    endfunction

    function automatic logic [31:0] outs_a();
        return pk(ifa.trans, ifa.busy, ifa.done, ifa.ch_idx);
    endfunction

    // Expected drive during one sweep: channel slot of ch_len cycles,
    // 30 cycles of bursts (4 high / 6 low), drive one cycle behind state.
    function automatic logic [3:0] exp_trans(input int n, input int ch_len);
        int m;
        logic [3:0] r;
        m = n - 1;
        r = 4'b0000;
        if (m >= 0 && m < 4 * ch_len && (m % ch_len) < 30 && (m % 10) < 4)
            r = 4'b0001 << (m / ch_len);
        return r;
    endfunction

    task automatic start_a();
        ifa.start = 1'b1;
        step();
        ifa.start = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1,   4'b0001, 1'b1, 1'b0, 2'd0};
        tbl[1]  = '{4,   4'b0001, 1'b1, 1'b0, 2'd0};
        tbl[2]  = '{5,   4'b0000, 1'b1, 1'b0, 2'd0};
        tbl[3]  = '{11,  4'b0001, 1'b1, 1'b0, 2'd0};
        tbl[4]  = '{30,  4'b0000, 1'b1, 1'b0, 2'd0};
        tbl[5]  = '{31,  4'b0000, 1'b1, 1'b0, 2'd0};
        tbl[6]  = '{50,  4'b0000, 1'b1, 1'b0, 2'd1};
        tbl[7]  = '{51,  4'b0010, 1'b1, 1'b0, 2'd1};
        tbl[8]  = '{101, 4'b0100, 1'b1, 1'b0, 2'd2};
        tbl[9]  = '{151, 4'b1000, 1'b1, 1'b0, 2'd3};
        tbl[10] = '{199, 4'b0000, 1'b1, 1'b0, 2'd3};
        tbl[11] = '{200, 4'b0000, 1'b0, 1'b1, 2'd0};
        tbl[12] = '{201, 4'b0000, 1'b0, 1'b0, 2'd0};

        ifa.start = 1'b0; ifa.stop = 1'b0; ifa.cont_mode = 1'b0;
        ifb.start = 1'b0; ifb.stop = 1'b0; ifb.cont_mode = 1'b0;
`ifdef TSCAN_CH_MASK_EN
        ifa.ch_mask = 4'b1111;
        ifb.ch_mask = 4'b1111;
`endif
        RST = 1'b1;
        repeat (3) step();
        check("reset_a", 0, outs_a(), 32'd0);
        check("reset_b", 0, pk(ifb.trans, ifb.busy, ifb.done, ifb.ch_idx), 32'd0);
        RST = 1'b0;
        step();

        // Single sweep on both builds (gap 2 and gap 0)
        ifa.start = 1'b1;
        ifb.start = 1'b1;
        step();
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        vi = 0; wa = 0; wb = 0;
        for (int n = 0; n <= 205; n++) begin
            if (vi < 13 && tbl[vi].cyc == n) begin
                check($sformatf("sweep_vec%0d", vi), n, outs_a(),
                      pk(tbl[vi].trans, tbl[vi].busy, tbl[vi].done, tbl[vi].ch));
                vi++;
            end
            if (ifa.trans !== exp_trans(n, 50)) wa++;
            if (ifb.trans !== exp_trans(n, 30)) wb++;
            if (n == 30)  check("gap0_last_low", n, {28'd0, ifb.trans}, 32'd0);
            if (n == 31)  check("gap0_abut", n, {28'd0, ifb.trans}, 32'h2);
            if (n == 120) check("gap0_done", n, {30'd0, ifb.busy, ifb.done}, 32'h1);
            step();
        end
        check("sweep_wave_a", 205, wa, 0);
        check("sweep_wave_gap0", 205, wb, 0);

        // Continuous mode, dropped during channel 3 of the second sweep
        ifa.cont_mode = 1'b1;
        start_a();
        dcount = 0;
        for (int n = 0; n <= 420; n++) begin
            if (ifa.done) dcount++;
            if (n == 200) check("cont_wrap", n, outs_a(), pk(4'b0000, 1'b1, 1'b0, 2'd0));
            if (n == 201) check("cont_restart", n, outs_a(), pk(4'b0001, 1'b1, 1'b0, 2'd0));
            if (n == 400) check("cont_end", n, outs_a(), pk(4'b0000, 1'b0, 1'b1, 2'd0));
            if (n == 360) ifa.cont_mode = 1'b0;
            step();
        end
        check("cont_done_count", 420, dcount, 1);

        // Stop mid-burst on channel 1
        start_a();
        quiet_err = 0;
        for (int n = 0; n <= 80; n++) begin
            if (n == 65) begin
                ifa.stop = 1'b0;
                check("stop_edge", n, outs_a(), 32'd0);
            end
            if (n > 65 && (ifa.trans !== 4'b0000 || ifa.done !== 1'b0 || ifa.busy !== 1'b0)) quiet_err++;
            if (n == 64) begin
                check("pre_stop", n, outs_a(), pk(4'b0010, 1'b1, 1'b0, 2'd1));
                ifa.stop = 1'b1;
            end
            step();
        end
        check("stop_quiet", 80, quiet_err, 0);

        // Restart after stop, start ignored while busy, reset with start
        start_a();
        for (int n = 0; n <= 121; n++) begin
            if (n == 1)   check("restart_ch0", n, outs_a(), pk(4'b0001, 1'b1, 1'b0, 2'd0));
            if (n == 70)  ifa.start = 1'b0;
            if (n == 75)  check("busy_start_ignored", n, outs_a(), pk(4'b0000, 1'b1, 1'b0, 2'd1));
            if (n == 101) check("busy_start_ch2", n, outs_a(), pk(4'b0100, 1'b1, 1'b0, 2'd2));
            if (n == 120) begin
                check("reset_with_start", n, outs_a(), 32'd0);
                RST = 1'b0;
                ifa.start = 1'b0;
            end
            if (n == 121) check("reset_stays_idle", n, outs_a(), 32'd0);
            if (n == 69) ifa.start = 1'b1;
            if (n == 119) begin
                RST = 1'b1;
                ifa.start = 1'b1;
            end
            if (n < 121) step();
        end

        ifa.start = 1'b1;
        ifa.stop  = 1'b1;
        step();
        ifa.start = 1'b0;
        ifa.stop  = 1'b0;
        check("start_stop_idle", 0, outs_a(), 32'd0);
        step();
        check("start_stop_idle_next", 1, outs_a(), 32'd0);

`ifdef TSCAN_CH_MASK_EN
        // Masked sweep over channels 1 and 3
        ifa.ch_mask = 4'b1010;
        start_a();
        quiet_err = 0;
        for (int n = 0; n <= 101; n++) begin
            if (ifa.trans[0] !== 1'b0 || ifa.trans[2] !== 1'b0) quiet_err++;
            if (n == 1)   check("mask_ch1", n, outs_a(), pk(4'b0010, 1'b1, 1'b0, 2'd1));
            if (n == 51)  check("mask_ch3", n, outs_a(), pk(4'b1000, 1'b1, 1'b0, 2'd3));
            if (n == 100) check("mask_done", n, outs_a(), pk(4'b0000, 1'b0, 1'b1, 2'd0));
            step();
        end
        check("mask_skipped", 101, quiet_err, 0);

        // Empty mask: immediate done, never busy
        ifa.ch_mask = 4'b0000;
        start_a();
        quiet_err = 0;
        for (int n = 0; n <= 10; n++) begin
            if (n == 0) check("mask0_done", n, outs_a(), pk(4'b0000, 1'b0, 1'b1, 2'd0));
            if (n == 1) check("mask0_after", n, outs_a(), 32'd0);
            if (ifa.trans !== 4'b0000 || ifa.busy !== 1'b0) quiet_err++;
            step();
        end
        check("mask0_quiet", 10, quiet_err, 0);
        ifa.ch_mask = 4'b1111;
`endif

        check("onehot", 0, onehot_err, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
